// File: rtl/alu_mult_seq.sv
// Purpose: shift-add sequencer producing the low WIDTH bits of an unsigned a*b via the shared ALU.
// Latency: done in cycle T+2+2n+p after start accepted at T (n = top set bit of b + 1, p = popcount b).
// Backpressure: start accepted only in IDLE; requests while busy or in DONE are dropped, not queued.
//
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   start, a, b         - multiply request and operands (captured when start is accepted)
//   busy, done, product - status, one-cycle completion pulse, result (held until next accepted start)
//   alu_op1/op2/control - drive to the shared ALU; alu_result is its combinational answer
module alu_mult_seq #(
  parameter int         WIDTH      = 32,
  parameter logic [2:0] CTRL_ADD   = 3'b000,
  parameter logic [2:0] CTRL_SHIFT = 3'b010
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic [WIDTH-1:0] alu_op1,
  output logic [WIDTH-1:0] alu_op2,
  output logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EVAL,
    S_ADD,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] product_q;

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      product_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
          end
        end
        S_ADD: begin
          acc <= alu_result;
        end
        S_SHIFT: begin
          mcand  <= alu_result;
          // Multiplier shift is local; the ALU is busy doubling mcand this cycle.
          mplier <= mplier >> 1;
        end
        S_DONE: begin
          product_q <= acc;
        end
        default: ;
      endcase
    end
  end

  // Next state and Moore outputs (ALU drive depends on state only).
  always_comb begin
    state_nxt   = state;
    busy        = 1'b0;
    done        = 1'b0;
    alu_control = CTRL_ADD;
    alu_op1     = '0;
    alu_op2     = '0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_EVAL;
      end
      S_EVAL: begin
        busy = 1'b1;
        // Early exit once no multiplier bits remain; a zero multiplicand does not shortcut.
        if (mplier == '0)     state_nxt = S_DONE;
        else if (mplier[0])   state_nxt = S_ADD;
        else                  state_nxt = S_SHIFT;
      end
      S_ADD: begin
        busy        = 1'b1;
        alu_control = CTRL_ADD;
        alu_op1     = acc;
        alu_op2     = mcand;
        state_nxt   = S_SHIFT;
      end
      S_SHIFT: begin
        busy        = 1'b1;
        alu_control = CTRL_SHIFT;
        alu_op1     = mcand;
        alu_op2     = ONE;
        state_nxt   = S_EVAL;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // acc is already final in DONE, so the result is visible in the done cycle itself.
  assign product = (state == S_DONE) ? acc : product_q;

endmodule

// File: tb/tb_alu_mult_seq.sv
module tb_alu_mult_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] product;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic [2:0]  alu_control;
  logic [31:0] alu_result;

  int total;
  int bad;

  // Per-run observations filled by run_mul.
  int          lat;
  int          shifts;
  int          real_adds;
  int          bad_op2;
  int          busy_gaps;
  logic [31:0] ctl_log;
  logic [31:0] last_prod;

  alu_mult_seq dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .product     (product),
    .alu_op1     (alu_op1),
    .alu_op2     (alu_op2),
    .alu_control (alu_control),
    .alu_result  (alu_result)
  );

  // Reference ALU: ADD and SHIFT only.
  assign alu_result = (alu_control == 3'b010) ? (alu_op1 << alu_op2) : (alu_op1 + alu_op2);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input logic [31:0] bv);
    int n;
    int p;
    n = 0;
    p = 0;
    for (int i = 0; i < 32; i++) begin
      if (bv[i]) begin
        n = i + 1;
        p++;
      end
    end
    return 2 + 2 * n + p;
  endfunction

  // Issue one multiply from IDLE and follow it to done; optionally pulse start at cycle 3.
  task automatic run_mul(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                         input bit pulse3);
    logic [31:0] expp;
    expp      = ia * ib;
    a         = ia;
    b         = ib;
    start     = 1'b1;
    lat       = 0;
    shifts    = 0;
    real_adds = 0;
    bad_op2   = 0;
    busy_gaps = 0;
    ctl_log   = '0;
    while (!done && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) begin
        start = 1'b0;
        chk({tag, "_hold_prev"}, product, last_prod);
      end
      if (pulse3 && lat == 3) start = 1'b1;
      if (pulse3 && lat == 4) start = 1'b0;
      ctl_log = (ctl_log << 3) | 32'(alu_control);
      if (alu_control == 3'b010) begin
        shifts++;
        if (alu_op2 !== 32'd1) bad_op2++;
      end
      if (alu_control == 3'b000 && (alu_op1 != 0 || alu_op2 != 0)) real_adds++;
      if (!done && !busy) busy_gaps++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat(ib)));
    chk({tag, "_prod_done"}, product, expp);
    chk({tag, "_shift_op2"}, 32'(bad_op2), 32'd0);
    chk({tag, "_busy"}, 32'(busy_gaps), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_done_width"}, 32'(done), 32'd0);
    chk({tag, "_prod_reg"}, product, expp);
    last_prod = expp;
  endtask

  initial begin
    int          dcount;
    int          dpos[3];
    int          maxrun;
    int          run;
    int          prod_bad;
    int          cyc;
    bit          sawdone;
    logic [31:0] ra;
    logic [31:0] rb;

    total     = 0;
    bad       = 0;
    last_prod = '0;
    reset     = 1'b1;
    start     = 1'b1;
    a         = 32'd5;
    b         = 32'd7;

    // Reset with start high: nothing may begin.
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_prod", product, 32'd0);
    chk("rst_ctl", 32'(alu_control), 32'd0);
    chk("rst_op1", alu_op1, 32'd0);
    chk("rst_op2", alu_op2, 32'd0);
    reset = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_busy", 32'(busy), 32'd0);

    // 7*6: cycle-by-cycle control is EVAL,SHIFT,EVAL,ADD,SHIFT,EVAL,ADD,SHIFT,EVAL,DONE.
    run_mul("mul7x6", 32'd7, 32'd6, 1'b0);
    chk("mul7x6_ctl_seq", ctl_log, 32'o0200200200);
    chk("mul7x6_shifts", 32'(shifts), 32'd3);
    chk("mul7x6_adds", 32'(real_adds), 32'd2);

    // b = 0: straight to DONE, no ALU activity.
    run_mul("b0", 32'h12345678, 32'd0, 1'b0);
    chk("b0_shifts", 32'(shifts), 32'd0);
    chk("b0_adds", 32'(real_adds), 32'd0);

    run_mul("b1", 32'hDEADBEEF, 32'd1, 1'b0);
    run_mul("ffxff", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    run_mul("msb_x2", 32'h80000000, 32'd2, 1'b0);
    run_mul("a0", 32'd0, 32'h00000105, 1'b0);

    // Start pulsed mid-operation is ignored.
    run_mul("ign3x5", 32'd3, 32'd5, 1'b1);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("ign_idle_busy", 32'(busy), 32'd0);
    chk("hold15", product, 32'd15);

    // Start held high: back-to-back multiplies, 10-cycle latency plus one IDLE cycle each.
    a        = 32'd3;
    b        = 32'd5;
    start    = 1'b1;
    dcount   = 0;
    maxrun   = 0;
    run      = 0;
    prod_bad = 0;
    cyc      = 0;
    while (dcount < 3 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) begin
        dpos[dcount] = cyc;
        dcount++;
        run++;
        if (product !== 32'd15) prod_bad++;
        if (dcount == 3) start = 1'b0;
      end else begin
        run = 0;
      end
      if (run > maxrun) maxrun = run;
    end
    chk("held_count", 32'(dcount), 32'd3);
    chk("held_first", 32'(dpos[0]), 32'd10);
    chk("held_gap1", 32'(dpos[1] - dpos[0]), 32'd11);
    chk("held_gap2", 32'(dpos[2] - dpos[1]), 32'd11);
    chk("held_width", 32'(maxrun), 32'd1);
    chk("held_prod", 32'(prod_bad), 32'd0);
    @(posedge clk);
    #1;
    chk("held_stop_busy", 32'(busy), 32'd0);
    last_prod = 32'd15;

    // Reset in the middle of a long multiply.
    a       = 32'h0000FFFF;
    b       = 32'h0000FFFF;
    start   = 1'b1;
    sawdone = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) start = 1'b0;
      if (done) sawdone = 1'b1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done | sawdone), 32'd0);
    chk("mid_rst_prod", product, 32'd0);
    @(posedge clk);
    #1;
    chk("mid_rst_idle", 32'(busy | done), 32'd0);
    last_prod = '0;
    run_mul("after_rst", 32'd2, 32'd3, 1'b0);

    // Random pairs; multiplier width varied to cover many latencies.
    for (int r = 0; r < 1000; r++) begin
      ra = $urandom;
      rb = $urandom;
      rb = rb >> $urandom_range(0, 31);
      run_mul("rand", ra, rb, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
